// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word per retired instruction and computes the next PC.
// Optional macro IFU_ALIGN_CHECK_EN traps misaligned next-PC targets into a sticky error state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic        npc_sel,
  input  logic        j_sel,
  input  logic        jr_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;

  logic [31:0] branch_off_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;
  logic        misaligned_s;

  // Next-PC target selection for the instruction currently held in instr_q.
  always_comb begin
    branch_off_s = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jr_sel) begin
      target_raw_s = rs_data;
    end else if (j_sel) begin
      target_raw_s = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (npc_sel && zero) begin
      target_raw_s = pc_plus4_q + branch_off_s;
    end else begin
      target_raw_s = pc_plus4_q;
    end
`ifdef IFU_ALIGN_CHECK_EN
    misaligned_s = (target_raw_s[1:0] != 2'b00);
    target_s     = target_raw_s;
`else
    misaligned_s = 1'b0;
    target_s     = target_raw_s & 32'hFFFF_FFFC;
`endif
  end

  // Fetch state machine: next state, next PC and registered-output values.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_plus4_d  = pc_plus4_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end else begin
          state_d = REQ;
        end
      end
      VALID: begin
        if (commit) begin
          pc_d       = target_s;
          pc_plus4_d = target_s + 32'd4;
          if (misaligned_s) begin
            state_d     = ERR;
            fetch_err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = VALID;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == VALID);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      instr_q       <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign fetch_err   = fetch_err_q;

endmodule
